aes_ecb_top: RTL and testbench

//  AES-256 ECB encryption engine (FIPS-197), single block, iterative one round per clock.

---
 rtl/aes_ecb_top.sv | 181 ++++++++++++++++++
 tb/tb_aes_ecb_top.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_top.sv
// AES-256 ECB encryption core: one round per clock, key schedule expanded on the fly.
// Key is loaded as eight 32-bit words; done pulses for one cycle when cipher_text is updated.
module aes_ecb_top (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  key_word,
  input  logic         valid_word,
  input  logic         start,
  input  logic [127:0] plain_text,
  output logic         done,
  output logic [127:0] cipher_text
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [255:0]   key_reg;
  logic [3:0]     word_cnt_reg;
  logic           key_loaded_reg;
  logic           start_prev_reg;
  logic [127:0]   aes_state_reg;
  logic [255:0]   wk_reg;
  logic [3:0]     round_reg;
  logic           done_reg;
  logic [127:0]   cipher_reg;

  logic           accept, busy, last_round, key_shift;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !start_prev_reg && key_loaded_reg) state_next = BUSY;
      BUSY:    if (round_reg == 4'd14) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    busy       = 1'b0;
    last_round = 1'b0;
    key_shift  = 1'b0;
    case (state_reg)
      IDLE: begin
        accept    = start && !start_prev_reg && key_loaded_reg;
        key_shift = valid_word;
      end
      BUSY: begin
        busy       = 1'b1;
        last_round = (round_reg == 4'd14);
      end
      default: ;
    endcase
  end

  // ---------------- Key load and start edge detect ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg        <= '0;
      word_cnt_reg   <= '0;
      key_loaded_reg <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      start_prev_reg <= start;
      if (key_shift) begin
        key_reg <= {key_reg[223:0], key_word};
        if (word_cnt_reg != 4'd8) word_cnt_reg <= word_cnt_reg + 4'd1;
        if (word_cnt_reg == 4'd7) key_loaded_reg <= 1'b1;
      end
    end
  end

  // ---------------- Round datapath ----------------
  logic [7:0]   sb_b [16];
  logic [7:0]   sr_b [16];
  logic [7:0]   mc_b [16];
  logic [127:0] round_key;
  logic [127:0] round_out;

  // The working key holds words w[4(r-1)..4(r-1)+7]; its lower half is round key r.
  assign round_key = wk_reg[127:0];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * (((gi / 4) + ROW) % 4) + ROW;
      assign sb_b[gi] = sbox(aes_state_reg[127-8*gi -: 8]);
      assign sr_b[gi] = sb_b[SRC];
      assign round_out[127-8*gi -: 8] = (last_round ? sr_b[gi] : mc_b[gi]) ^ round_key[127-8*gi -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_b[4*gi];
      assign a1 = sr_b[4*gi+1];
      assign a2 = sr_b[4*gi+2];
      assign a3 = sr_b[4*gi+3];
      assign mc_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // ---------------- Key schedule: four new words per round ----------------
  logic [31:0]  sub_w, temp_w, n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [255:0] wk_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ksbox
      assign sub_w[31-8*gi -: 8] = sbox(wk_reg[31-8*gi -: 8]);
    end
  endgenerate

  // Odd rounds produce word i with i%8==0 (RotWord+Rcon), even rounds i%8==4 (SubWord only).
  assign rcon    = 8'h01 << round_reg[3:1];
  assign temp_w  = round_reg[0] ? ({sub_w[23:0], sub_w[31:24]} ^ {rcon, 24'h0}) : sub_w;
  assign n0      = wk_reg[255:224] ^ temp_w;
  assign n1      = wk_reg[223:192] ^ n0;
  assign n2      = wk_reg[191:160] ^ n1;
  assign n3      = wk_reg[159:128] ^ n2;
  assign wk_next = {wk_reg[127:0], n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (reset) begin
      aes_state_reg <= '0;
      wk_reg        <= '0;
      round_reg     <= '0;
      done_reg      <= 1'b0;
      cipher_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        aes_state_reg <= plain_text ^ key_reg[255:128];
        wk_reg        <= key_reg;
        round_reg     <= 4'd1;
      end else if (busy) begin
        aes_state_reg <= round_out;
        wk_reg        <= wk_next;
        round_reg     <= round_reg + 4'd1;
        if (last_round) begin
          cipher_reg <= round_out;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done        = done_reg;
  assign cipher_text = cipher_reg;

endmodule

// File: tb/tb_aes_ecb_top.sv
// Self-checking bench for aes_ecb_top: directed FIPS-197 cases plus random keys/plaintexts
// compared against an algebraic AES-256 reference model.
module tb_aes_ecb_top;

  logic         clk;
  logic         reset;
  logic [31:0]  key_word;
  logic         valid_word;
  logic         start;
  logic [127:0] plain_text;
  logic         done;
  logic [127:0] cipher_text;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] sbox_t [256];

  aes_ecb_top dut (
    .clk(clk), .reset(reset), .key_word(key_word), .valid_word(valid_word),
    .start(start), .plain_text(plain_text), .done(done), .cipher_text(cipher_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  // ---------------- Reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          u[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 14)
            s[r][c] = gmul(8'h02, u[r][c]) ^ gmul(8'h03, u[(r+1)%4][c]) ^ u[(r+2)%4][c] ^ u[(r+3)%4][c];
          else
            s[r][c] = u[r][c];
          s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = s[r][c];
    return out;
  endfunction

  // ---------------- Check helpers ----------------
  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [255:0] k, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      key_word   = k[255-32*i -: 32];
      valid_word = 1'b1;
      tick();
    end
    valid_word = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(input int hold, output logic [127:0] ct, output int lat);
    lat = -1;
    ct  = '0;
    for (int cyc = 1; cyc <= 30 && lat < 0; cyc++) begin
      if (cyc >= hold) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc;
        ct  = cipher_text;
      end else begin
        tick();
      end
    end
  endtask

  task automatic run_enc(input logic [127:0] pt, input int hold, output logic [127:0] ct, output int lat);
    plain_text = pt;
    start      = 1'b1;
    tick();
    wait_done(hold, ct, lat);
    tick();
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- Directed and random sequence ----------------
  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K2 = 256'h31302928272625242322212019181716151413121110090807060504030201_00;
  localparam logic [127:0] P2 = 128'h00010203040506070809101112131415;

  initial begin
    logic [255:0] k;
    logic [127:0] ct, ct_b, pa, pb;
    int lat, lat_b, cnt0;

    reset = 1'b1; start = 1'b0; valid_word = 1'b0; key_word = '0; plain_text = '0;
    build_sbox();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check_int("reset_done", int'(done), 0);
    check128("reset_cipher", cipher_text, '0);
    tick();

    // Test 1: FIPS-197 AES-256 vector, single-cycle start
    load_words(K1, 0, 8);
    cnt0 = done_cnt;
    run_enc(P1, 1, ct, lat);
    check128("t1_cipher_kat", ct, C1);
    check128("t1_cipher_model", ct, model_encrypt(K1, P1));
    check_int("t1_latency", lat, 15);
    @(negedge clk);
    check_int("t1_done_pulse_width", int'(done), 0);
    repeat (5) tick();
    check_int("t1_done_count", done_cnt - cnt0, 1);
    check128("t1_cipher_held", cipher_text, C1);
    $display("txn t1 key=%h pt=%h ct=%h lat=%0d", K1, P1, ct, lat);

    // Test 6: key words during BUSY are ignored
    plain_text = P1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_word = $urandom;
      valid_word = 1'b1;
      tick();
    end
    valid_word = 1'b0;
    wait_done(1, ct, lat);
    tick();
    check_int("t6_latency_remaining", lat, 10);
    check128("t6_cipher_busy_words", ct, C1);
    run_enc(P1, 1, ct, lat);
    check128("t6_key_retained", ct, C1);
    $display("txn t6 ct=%h", ct);

    // Test 2: second key, start held two cycles
    load_words(K2, 0, 8);
    cnt0 = done_cnt;
    run_enc(P2, 2, ct, lat);
    repeat (20) tick();
    check128("t2_cipher_model", ct, model_encrypt(K2, P2));
    check_int("t2_single_done", done_cnt - cnt0, 1);
    $display("txn t2 key=%h pt=%h ct=%h lat=%0d", K2, P2, ct, lat);

    // Test 3: start with a partially loaded key is ignored
    reset = 1'b1; tick(); reset = 1'b0;
    k = rand256();
    load_words(k, 0, 5);
    cnt0 = done_cnt;
    run_enc(rand128(), 1, ct, lat);
    check_int("t3_no_done_latency", lat, -1);
    check_int("t3_no_done_count", done_cnt - cnt0, 0);
    load_words(k, 5, 3);
    pa = rand128();
    run_enc(pa, 1, ct, lat);
    check128("t3_cipher_model", ct, model_encrypt(k, pa));
    check_int("t3_latency", lat, 15);
    $display("txn t3 key=%h pt=%h ct=%h lat=%0d", k, pa, ct, lat);

    // Test 4: back-to-back start in the done cycle
    k = rand256();
    load_words(k, 0, 8);
    pa = rand128();
    pb = rand128();
    plain_text = pa;
    start = 1'b1;
    tick();
    wait_done(1, ct, lat);
    plain_text = pb;
    start = 1'b1;
    tick();
    wait_done(1, ct_b, lat_b);
    tick();
    check128("t4_cipher_a", ct, model_encrypt(k, pa));
    check_int("t4_latency_a", lat, 15);
    check128("t4_cipher_b", ct_b, model_encrypt(k, pb));
    check_int("t4_latency_b", lat_b, 15);
    $display("txn t4 key=%h ct_a=%h ct_b=%h", k, ct, ct_b);

    // Test 5: reset in the middle of an encryption
    load_words(K1, 0, 8);
    cnt0 = done_cnt;
    plain_text = P1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check_int("t5_done_after_reset", int'(done), 0);
    check128("t5_cipher_after_reset", cipher_text, '0);
    tick();
    run_enc(P1, 1, ct, lat);
    check_int("t5_start_ignored", lat, -1);
    check_int("t5_no_done", done_cnt - cnt0, 0);
    k = rand256();
    load_words(k, 0, 8);
    pa = rand128();
    run_enc(pa, 1, ct, lat);
    check128("t5_cipher_reload", ct, model_encrypt(k, pa));
    $display("txn t5 key=%h pt=%h ct=%h lat=%0d", k, pa, ct, lat);

    // Random keys and plaintexts
    for (int n = 0; n < 4; n++) begin
      k  = rand256();
      pa = rand128();
      load_words(k, 0, 8);
      run_enc(pa, 1 + (n % 3), ct, lat);
      check128("rand_cipher", ct, model_encrypt(k, pa));
      check_int("rand_latency", lat, 15);
      $display("txn rand%0d key=%h pt=%h ct=%h lat=%0d", n, k, pa, ct, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
